// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: program-load, run-control, UART handshake and
// datapath-issue signals of the instruction sequencer.
// master = the controlling environment, slave = the sequencer itself.
interface instr_sequencer_if;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  prog_len;
    logic        start;
    logic        abort;
    logic        tx_done;
    logic [14:0] instruction;
    logic        step_valid;
    logic [3:0]  pc;
    logic        tx_start;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output prog_we, prog_addr, prog_data, prog_len, start, abort, tx_done,
        input  instruction, step_valid, pc, tx_start, busy, done, err
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, prog_len, start, abort, tx_done,
        output instruction, step_valid, pc, tx_start, busy, done, err
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: steps through a 16-word program memory, issuing one
// datapath instruction per cycle and optionally pausing after a word until
// the UART reports a completed transmission (rising edge of tx_done).
// Optional feature macro: SEQ_TX_TIMEOUT_EN -- bounds the UART wait to
// TIMEOUT cycles and raises the sticky err flag when it expires.
module instr_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic             clk,
    input  logic             reset,
    instr_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_TX, DONE} state_t;

    state_t      state;
    logic [15:0] mem [16];
    logic [3:0]  len_q;
    logic [3:0]  pc_q;
    logic [14:0] instr_q;
    logic        step_valid_q;
    logic        tx_start_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        tx_done_p1;

    logic [3:0]  pc_next;
    logic [15:0] word_cur;
    logic [15:0] word_next;
    logic [15:0] word_first;
    logic        last_step;
    logic        tx_rise;

`ifdef SEQ_TX_TIMEOUT_EN
    logic [15:0] wait_cnt;
`else
    logic        unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    assign pc_next   = pc_q + 4'd1;
    assign word_cur  = mem[pc_q];
    assign word_next = mem[pc_next];
    // A write to address 0 in the same cycle as start must reach the first issue.
    assign word_first = (bus.prog_we && (bus.prog_addr == 4'd0)) ? bus.prog_data : mem[4'd0];
    assign last_step = (pc_q == len_q);
    assign tx_rise   = bus.tx_done & ~tx_done_p1;

    // Program memory: loadable only while idle, never cleared by reset.
    always_ff @(posedge clk) begin
        if (bus.prog_we && (state == IDLE)) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // Sequencer state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            len_q        <= 4'd0;
            pc_q         <= 4'd0;
            instr_q      <= 15'h0;
            step_valid_q <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            tx_done_p1   <= 1'b0;
`ifdef SEQ_TX_TIMEOUT_EN
            wait_cnt     <= 16'd0;
`endif
        end else begin
            tx_done_p1   <= bus.tx_done;
            step_valid_q <= 1'b0;
            instr_q      <= 15'h0;
            done_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state        <= ISSUE;
                        len_q        <= bus.prog_len;
                        pc_q         <= 4'd0;
                        busy_q       <= 1'b1;
                        err_q        <= 1'b0;
                        step_valid_q <= 1'b1;
                        instr_q      <= word_first[14:0];
                    end
                end
                ISSUE: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        pc_q       <= 4'd0;
                        tx_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (word_cur[15]) begin
                        state      <= WAIT_TX;
                        tx_start_q <= 1'b1;
`ifdef SEQ_TX_TIMEOUT_EN
                        wait_cnt   <= 16'd0;
`endif
                    end else if (last_step) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        state        <= ISSUE;
                        pc_q         <= pc_next;
                        step_valid_q <= 1'b1;
                        instr_q      <= word_next[14:0];
                    end
                end
                WAIT_TX: begin
                    if (bus.abort) begin
                        state      <= IDLE;
                        pc_q       <= 4'd0;
                        tx_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else if (tx_rise) begin
                        tx_start_q <= 1'b0;
                        if (last_step) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state        <= ISSUE;
                            pc_q         <= pc_next;
                            step_valid_q <= 1'b1;
                            instr_q      <= word_next[14:0];
                        end
                    end
`ifdef SEQ_TX_TIMEOUT_EN
                    else if (wait_cnt == (TIMEOUT - 16'd1)) begin
                        state      <= IDLE;
                        pc_q       <= 4'd0;
                        tx_start_q <= 1'b0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
`endif
                end
                DONE: begin
                    state      <= IDLE;
                    pc_q       <= 4'd0;
                    tx_start_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    pc_q   <= 4'd0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instruction = instr_q;
    assign bus.step_valid  = step_valid_q;
    assign bus.pc          = pc_q;
    assign bus.tx_start    = tx_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd5000, meaning WAIT_TX cycle limit (used only with SEQ_TX_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port prog_we  input  1  program-memory write strobe.
REQ-005 SHALL have port prog_addr  input  4  program-memory write address.
REQ-006 SHALL have port prog_data  input  16  program word: [15] send-after flag, [14:0] datapath instruction.
REQ-007 SHALL have port prog_len  input  4  last address executed (inclusive), sampled on start.
REQ-008 SHALL have port start  input  1  begin execution at address 0.
REQ-009 SHALL have port abort  input  1  terminate execution.
REQ-010 SHALL have port tx_done  input  1  UART transmission-complete level.
REQ-011 SHALL have port instruction  output  15  instruction word to datapath.
REQ-012 SHALL have port step_valid  output  1  instruction is valid this cycle.
REQ-013 SHALL have port pc  output  4  address of current word.
REQ-014 SHALL have port tx_start  output  1  UART send request for regA.
REQ-015 SHALL have port busy  output  1  high in ISSUE, WAIT_TX and DONE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-018 SHALL hold a 16x16 program memory, written when prog_we=1 in IDLE; writes while busy are ignored.
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_TX, DONE in a registered state machine.
REQ-020 SHALL, in IDLE with start=1, latch prog_len, set pc=0 and enter ISSUE next cycle; start is ignored when busy.
REQ-021 SHALL, on simultaneous prog_we and start in IDLE, perform the write and have it visible to the run.
REQ-022 SHALL, in ISSUE, drive instruction=mem[pc][14:0] and step_valid=1 for exactly one cycle.
REQ-023 SHALL drive instruction=15'h0 whenever step_valid=0.
REQ-024 SHALL, after ISSUE with flag=0, either go to ISSUE with pc+1 (back-to-back) or to DONE if pc==latched prog_len.
REQ-025 SHALL, after ISSUE with flag=1, enter WAIT_TX with tx_start=1 held until a 0->1 edge of tx_done (registered previous value); a stale high tx_done does not complete.
REQ-026 SHALL, on that tx_done edge, deassert tx_start next cycle and advance as in REQ-024.
REQ-027 SHALL, in DONE, pulse done=1 for one cycle and return to IDLE with pc=0.
REQ-028 SHALL never wrap pc; prog_len=15 ends after address 15.
REQ-029 SHALL, on abort=1 in any busy state, enter IDLE next cycle with tx_start=0, step_valid=0, no done pulse; abort has priority over tx_done and start.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, enter IDLE with pc=0, instruction=0, step_valid=0, tx_start=0, busy=0, done=0, err=0, regardless of state.
REQ-031 SHALL NOT clear program memory on reset.

Configuration
REQ-032 SHALL, with SEQ_TX_TIMEOUT_EN defined, count WAIT_TX cycles and, when the count reaches TIMEOUT, set err=1 and enter IDLE (no done); err clears on reset or next accepted start.
REQ-033 SHALL, without SEQ_TX_TIMEOUT_EN, omit the counter, tie err=0 and wait in WAIT_TX indefinitely.

Verification
REQ-034 SHALL test: load 0x0101,0x0102,0x0103,0x0104; prog_len=3; start at cycle N -> step_valid N+1..N+4 with pc 0..3 and instructions 0x101..0x104, done at N+5.
REQ-035 SHALL test: word1=0x8203, prog_len=1, tx_done held high, then falls, then rises 20 cycles later -> tx_start high until the cycle after the rise, then done.
REQ-036 SHALL test: abort during WAIT_TX -> IDLE next cycle, tx_start=0, done stays 0.
REQ-037 SHALL test: prog_we while busy to addr 0 with 0x7FFF -> next run issues the old word.
REQ-038 SHALL test: with SEQ_TX_TIMEOUT_EN and TIMEOUT=10, tx_done stuck 0 -> err=1 after 10 WAIT_TX cycles, state IDLE.
REQ-039 SHALL test: reset asserted in ISSUE at pc=2 -> all outputs 0 next cycle; a rerun returns the pre-reset memory contents.
